// File: rtl/glove_pkg.sv
// Shared definitions for the glove event path: event codes, drain FSM states,
// and a saturating 16-bit accumulator used by the drop counter.
package glove_pkg;

    localparam logic [7:0] EV_UP           = 8'd0;
    localparam logic [7:0] EV_DOWN         = 8'd1;
    localparam logic [7:0] EV_LEFT         = 8'd2;
    localparam logic [7:0] EV_RIGHT        = 8'd3;
    localparam logic [7:0] EV_CLICK        = 8'd4;
    localparam logic [7:0] EV_SCROLL_UP    = 8'd6;
    localparam logic [7:0] EV_SCROLL_DN    = 8'd7;
    localparam logic [7:0] EV_RESET_CURSOR = 8'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2,
        BUSY  = 2'd3
    } drain_state_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] base, input logic [15:0] inc);
        logic [16:0] sum;
        sum = {1'b0, base} + {1'b0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/glove_event_scheduler_byte_fifo.sv
// Byte FIFO with extra-MSB pointers so all DEPTH slots are usable;
// the head entry is presented combinationally on rd_data.
module byte_fifo #(
    parameter int W      = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [W-1:0]      wr_data,
    input  logic              rd_en,
    output logic [W-1:0]      rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level
);
    localparam int PW = ADDR_W + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic          wr_ok_s;
    logic          rd_ok_s;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign wr_ok_s = wr_en && !full;
    assign rd_ok_s = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q[ADDR_W-1:0]];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
        end
    end

    // Pointer update; wraps naturally modulo 2*DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_ok_s) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (rd_ok_s) rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

endmodule

// File: rtl/glove_event_scheduler.sv
// Latches per-source event pulses, arbitrates them round-robin into a byte
// FIFO and drains the FIFO to the UART with a send/ready handshake.
module glove_event_scheduler
    import glove_pkg::*;
#(
    parameter int N_REQ       = 5,
    parameter int CODE_W      = 8,
    parameter int DEPTH       = 64,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*CODE_W-1:0] req_code,
    input  logic                    enable,
    input  logic                    uart_ready,
    output logic                    uart_send,
    output logic [CODE_W-1:0]       uart_data,
    output logic [ADDR_W:0]         fifo_level,
    output logic [15:0]             drop_count,
    output logic                    busy
);
    localparam int RR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    logic [N_REQ-1:0]  pending_q, pending_d;
    logic [CODE_W-1:0] code_q [N_REQ];
    logic [CODE_W-1:0] code_d [N_REQ];
    logic [15:0]       drop_q, drop_d;
    logic [RR_W-1:0]   rr_q;
    logic              gnt_valid_s;
    logic [RR_W-1:0]   gnt_idx_s;
    logic [15:0]       drop_inc_s;

    drain_state_t      state_q;
    logic [TMR_W-1:0]  tmr_q;
    logic              send_q;
    logic [CODE_W-1:0] data_q;

    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              fifo_rd_s;
    logic [CODE_W-1:0] fifo_head_s;

    // Round-robin search from the slot after the last winner; a full FIFO blocks all grants.
    always_comb begin
        int idx_v;
        gnt_valid_s = 1'b0;
        gnt_idx_s   = '0;
        idx_v       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx_v = (int'(rr_q) + k) % N_REQ;
            if (!gnt_valid_s && pending_q[idx_v] && !fifo_full_s) begin
                gnt_valid_s = 1'b1;
                gnt_idx_s   = RR_W'(idx_v);
            end else begin
                gnt_valid_s = gnt_valid_s;
            end
        end
    end

    // Pending latch next state: a granted slot re-arms if a new pulse arrives the same cycle.
    always_comb begin
        drop_inc_s = 16'd0;
        for (int i = 0; i < N_REQ; i++) begin
            pending_d[i] = pending_q[i];
            code_d[i]    = code_q[i];
            if (gnt_valid_s && (gnt_idx_s == RR_W'(i))) begin
                pending_d[i] = req[i];
            end else if (req[i] && pending_q[i]) begin
                drop_inc_s = drop_inc_s + 16'd1;
            end else begin
                pending_d[i] = pending_q[i];
            end
            if (req[i]) begin
                pending_d[i] = 1'b1;
                code_d[i]    = req_code[i*CODE_W +: CODE_W];
            end else begin
                code_d[i]    = code_q[i];
            end
        end
        drop_d = sat_add16(drop_q, drop_inc_s);
    end

    // Request-side state: pending flags, captured codes, drop counter, round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
            drop_q    <= 16'd0;
            rr_q      <= '0;
            for (int i = 0; i < N_REQ; i++) code_q[i] <= '0;
        end else begin
            pending_q <= pending_d;
            drop_q    <= drop_d;
            for (int i = 0; i < N_REQ; i++) code_q[i] <= code_d[i];
            if (gnt_valid_s) rr_q <= gnt_idx_s;
        end
    end

    byte_fifo #(
        .W      (CODE_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .wr_en   (gnt_valid_s),
        .wr_data (code_q[gnt_idx_s]),
        .rd_en   (fifo_rd_s),
        .rd_data (fifo_head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (fifo_level)
    );

    assign fifo_rd_s = (state_q == IDLE) && enable && uart_ready && !fifo_empty_s;

    // Drain FSM: one strobe per byte, then wait for ready to cycle low/high or time out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            send_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    tmr_q <= '0;
                    if (fifo_rd_s) begin
                        data_q  <= fifo_head_s;
                        send_q  <= 1'b1;
                        state_q <= ISSUE;
                    end else begin
                        send_q  <= 1'b0;
                    end
                end
                ISSUE: begin
                    send_q  <= 1'b0;
                    tmr_q   <= '0;
                    state_q <= ACK;
                end
                ACK: begin
                    send_q <= 1'b0;
                    if (!uart_ready) begin
                        tmr_q   <= '0;
                        state_q <= BUSY;
                    end else if (tmr_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                        tmr_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        tmr_q   <= tmr_q + TMR_W'(1);
                    end
                end
                BUSY: begin
                    send_q <= 1'b0;
                    if (uart_ready) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= BUSY;
                    end
                end
                default: begin
                    send_q  <= 1'b0;
                    tmr_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign uart_send  = send_q;
    assign uart_data  = data_q;
    assign drop_count = drop_q;
    assign busy       = !fifo_empty_s || (|pending_q) || (state_q != IDLE);

endmodule

// File: tb/tb_glove_event_scheduler.sv
// Directed bench for glove_event_scheduler: single event, round-robin order,
// coalescing, full boundary, pointer wrap, handshake spacing and async reset.
module tb_glove_event_scheduler;
    import glove_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  req;
    logic [39:0] req_code;
    logic        enable;
    logic        uart_ready;
    logic        uart_send;
    logic [7:0]  uart_data;
    logic [6:0]  fifo_level;
    logic [15:0] drop_count;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] sent_q [$];
    int         stamp_q [$];
    logic       prev_send = 1'b0;
    logic       b2b = 1'b0;

    glove_event_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_code   (req_code),
        .enable     (enable),
        .uart_ready (uart_ready),
        .uart_send  (uart_send),
        .uart_data  (uart_data),
        .fifo_level (fifo_level),
        .drop_count (drop_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every send strobe with its byte and cycle stamp.
    always @(negedge clk) begin
        if (rst && uart_send) begin
            sent_q.push_back(uart_data);
            stamp_q.push_back(cyc);
            if (prev_send) b2b <= 1'b1;
        end
        prev_send <= rst && uart_send;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_sends(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (sent_q.size() < n && c < budget) begin
            step(1);
            c++;
        end
        check(tag, sent_q.size(), n);
    endtask

    logic [7:0] exp_burst [17];
    int base;
    int cnt;

    initial begin
        exp_burst = '{EV_CLICK,
                      EV_UP, EV_DOWN, EV_LEFT, EV_RIGHT, EV_CLICK,
                      EV_UP, EV_DOWN, EV_LEFT, EV_RIGHT, EV_CLICK,
                      EV_DOWN,
                      EV_LEFT, EV_RIGHT, EV_CLICK, EV_UP, EV_DOWN};
        rst        = 1'b0;
        req        = 5'd0;
        req_code   = {EV_CLICK, EV_RIGHT, EV_LEFT, EV_DOWN, EV_UP};
        enable     = 1'b1;
        uart_ready = 1'b1;
        step(3);
        check("rst_send",  uart_send, 1'b0);
        check("rst_data",  uart_data, 8'h00);
        check("rst_level", fifo_level, 7'd0);
        check("rst_busy",  busy, 1'b0);
        check("rst_drop",  drop_count, 16'd0);
        rst = 1'b1;
        step(2);

        // Single event from requester 2
        req = 5'b00100;
        step(1);
        req = 5'd0;
        check("se_lvl0", fifo_level, 7'd0);
        check("se_busy", busy, 1'b1);
        step(1);
        check("se_lvl1", fifo_level, 7'd1);
        check("se_nosend", uart_send, 1'b0);
        step(1);
        check("se_send", uart_send, 1'b1);
        check("se_data", uart_data, 8'd2);
        check("se_lvl_after_rd", fifo_level, 7'd0);
        uart_ready = 1'b0;
        step(10);
        check("se_send_low", uart_send, 1'b0);
        check("se_busy_wait", busy, 1'b1);
        uart_ready = 1'b1;
        step(1);
        check("se_idle_busy", busy, 1'b0);
        check("se_idle_lvl", fifo_level, 7'd0);
        check("se_one_send", sent_q.size(), 1);
        check("se_sent_byte", sent_q[0], 8'd2);

        // Round-robin order: prime rr_ptr=4, two full bursts, then rr_ptr=1 and a burst
        enable = 1'b0;
        req = 5'b10000; step(1); req = 5'd0; step(8);
        req = 5'b11111; step(1); req = 5'd0; step(8);
        req = 5'b11111; step(1); req = 5'd0; step(8);
        req = 5'b00010; step(1); req = 5'd0; step(8);
        req = 5'b11111; step(1); req = 5'd0; step(8);
        check("rr_level", fifo_level, 7'd17);
        check("rr_drop", drop_count, 16'd0);
        enable = 1'b1;
        wait_sends(18, 300, "rr_drain_timeout");
        for (int i = 0; i < 17; i++) begin
            if (i + 1 < sent_q.size()) check($sformatf("rr_order_%0d", i), sent_q[i+1], exp_burst[i]);
            else check($sformatf("rr_missing_%0d", i), sent_q.size(), i + 2);
        end
        if (stamp_q.size() >= 3) check("rr_spacing", stamp_q[2] - stamp_q[1], 10);
        else check("rr_spacing_missing", stamp_q.size(), 3);
        step(12);
        check("rr_idle", busy, 1'b0);

        // Full boundary with same-cycle re-request streaming, then coalescing while full
        base = sent_q.size();
        enable = 1'b0;
        for (int k = 0; k < 64; k++) begin
            req = 5'b01000;
            req_code[3*8 +: 8] = 8'h80 + 8'(k);
            step(1);
        end
        req = 5'd0;
        step(3);
        check("full_level", fifo_level, 7'd64);
        check("full_nodrop", drop_count, 16'd0);
        for (int j = 0; j < 3; j++) begin
            req = 5'b00001;
            req_code[7:0] = 8'h10 + 8'(j);
            step(1);
            req = 5'd0;
            step(1);
        end
        check("coal_drop", drop_count, 16'd2);
        check("coal_level", fifo_level, 7'd64);
        check("coal_busy", busy, 1'b1);
        enable = 1'b1;
        wait_sends(base + 65, 800, "full_drain_timeout");
        for (int k = 0; k < 64; k++) begin
            if (base + k < sent_q.size()) check($sformatf("full_byte_%0d", k), sent_q[base+k], 8'h80 + 8'(k));
            else check($sformatf("full_missing_%0d", k), sent_q.size(), base + k + 1);
        end
        if (base + 64 < sent_q.size()) check("coal_byte", sent_q[base+64], 8'h12);
        else check("coal_missing", sent_q.size(), base + 65);
        for (int k = 1; k < 65; k++) begin
            if (base + k < stamp_q.size())
                check($sformatf("gap_%0d", k), stamp_q[base+k] - stamp_q[base+k-1], 10);
        end
        check("no_back_to_back", b2b, 1'b0);
        step(12);

        // Pointer wrap: another 64 entries past 2*DEPTH total writes
        base = sent_q.size();
        enable = 1'b0;
        for (int k = 0; k < 64; k++) begin
            req = 5'b00100;
            req_code[2*8 +: 8] = 8'h40 + 8'(k);
            step(1);
        end
        req = 5'd0;
        step(3);
        check("wrap_level", fifo_level, 7'd64);
        enable = 1'b1;
        wait_sends(base + 64, 800, "wrap_drain_timeout");
        for (int k = 0; k < 64; k++) begin
            if (base + k < sent_q.size()) check($sformatf("wrap_byte_%0d", k), sent_q[base+k], 8'h40 + 8'(k));
            else check($sformatf("wrap_missing_%0d", k), sent_q.size(), base + k + 1);
        end
        step(12);
        check("wrap_idle_busy", busy, 1'b0);
        check("wrap_idle_lvl", fifo_level, 7'd0);

        // Asynchronous reset during ISSUE with five bytes queued
        req_code = {EV_CLICK, EV_RIGHT, EV_LEFT, EV_DOWN, EV_UP};
        enable = 1'b0;
        req = 5'b11111; step(1); req = 5'd0; step(8);
        check("mr_level", fifo_level, 7'd5);
        enable = 1'b1;
        step(1);
        check("mr_issue_send", uart_send, 1'b1);
        cnt = sent_q.size();
        #2 rst = 1'b0;
        #1;
        check("mr_send_drop", uart_send, 1'b0);
        check("mr_level_clr", fifo_level, 7'd0);
        check("mr_busy_clr", busy, 1'b0);
        check("mr_drop_clr", drop_count, 16'd0);
        step(1);
        rst = 1'b1;
        step(20);
        check("mr_no_send", sent_q.size(), cnt);
        check("mr_busy_after", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
